seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Time-multiplexed driver for a bank of common-anode 7-segment digits. It generalises the single-digit hex/extended decoder into a block with these properties:
- parametrised digit count, one shared active-low segment bus and one-hot active-low digit enables;
- double-buffered display content, leading-zero suppression, per-digit blanking, per-digit blinking and an anti-ghosting dead time.

It sits between the datapath (counters, FSM status) and the board display pins.

## Interface
Parameters:
- DIGITS, 4, number of digits (1..8); digit 0 is least significant (rightmost).
- SCAN_DIV, 50000, clock cycles per digit slot (≥ 2).
- DEAD, 500, cycles at slot start with all digits disabled (0 ≤ DEAD < SCAN_DIV).
- BLINK_FRAMES, 100, full scan frames per blink half-period (≥ 1).

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  synchronous reset, active-low.
- load  in  1  capture strobe for all content inputs below.
- data  in  4*DIGITS  nibble i at [4i+3:4i] is the code for digit i.
- ext_mode  in  1  0 = hex alphabet, 1 = extended alphabet.
- dp_in  in  DIGITS  decimal point per digit, 1 = lit.
- blank_mask  in  DIGITS  1 = digit forced dark, including its DP.
- blink_en  in  DIGITS  1 = digit dark during the blink-off phase.
- lz_en  in  1  leading-zero suppression enable.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low.
- an  out  DIGITS  digit enables, active-low, at most one low.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

## Operation
Shadow registers:
- load=1 at an edge copies data, ext_mode, dp_in, blank_mask, blink_en and lz_en into shadow registers.
- Only the shadow registers feed the display.
- With load=0 the inputs are ignored.

Scan:
- Prescaler pcnt counts 0..SCAN_DIV-1 and wraps.
- On wrap, digit index idx increments and wraps DIGITS-1 → 0.
- The edge on which idx wraps raises frame_done for exactly one cycle.

Blink:
- Frame counter fcnt counts frame_done pulses 0..BLINK_FRAMES-1.
- On its wrap, blink phase bph toggles; bph=1 is the off phase.

Digit dark condition: digit idx is dark if any of the following holds:
- blank_mask[idx];
- blink_en[idx] and bph=1;
- leading-zero suppressed.

Leading-zero suppression:
- Applies only when lz_en=1 and ext_mode=0.
- Digit i (i ≥ 1) is suppressed iff nibbles DIGITS-1 down to i are all 0.
- Digit 0 is never suppressed.

Hex decode (gfedcba):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0011000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110

Extended decode:
- A (4'hA) = 0001000, b (4'hB) = 0000011, r (4'hC) = 0101111.
- Every other code = 1111111.

Outputs:
- Dark digit: seg=1111111, dp_n=1. The anode is still driven, so timing is unchanged.
- Dead time: when pcnt < DEAD, an is all ones and seg/dp_n are 1111111/1.
- Otherwise: an[idx]=0 and all other bits are 1.

## Timing
- Reset (rst_n=0 at an edge):
  - pcnt=0, idx=0, fcnt=0, bph=0, shadow registers all 0;
  - seg=7'h7F, dp_n=1, an all ones, frame_done=0.
- Reset mid-frame takes effect at that edge and overrides load.
- seg, dp_n and an are registered. They reflect the (pcnt, idx, bph, shadow) state present before the same edge, i.e. they lag the counters by 1 cycle.
- Load latency: load sampled at edge k updates the shadow registers at k; the new content is on the pins after edge k+1 if the digit is active.
- Simultaneous load and slot/frame wrap: both take effect; the new digit shows the new content.
- frame_done is registered and asserted in the cycle following the idx wrap edge.
- Slot period is exactly SCAN_DIV cycles; frame period is DIGITS*SCAN_DIV; blink half-period is BLINK_FRAMES*DIGITS*SCAN_DIV.
- Reset exit: the first frame starts at digit 0 with pcnt=0 on the first edge with rst_n=1.
- DIGITS=1: idx stays 0 and frame_done pulses every SCAN_DIV cycles.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=8, DEAD=2, BLINK_FRAMES=2 unless stated.

1. Reset then load data=16'h12AF, ext_mode=0 → per slot: an=1111 for 2 cycles, then 6 cycles each of:
   - an=1110, seg=0001110;
   - an=1101, seg=0001000;
   - an=1011, seg=0100100;
   - an=0111, seg=1111001.
   frame_done pulses every 32 cycles.
2. ext_mode=1, data=16'hABC5 → digits 3..0 show 0001000, 0000011, 0101111, 1111111.
3. lz_en=1, data=16'h0040:
   - digits 3 and 2 dark; digit 1 = 0011001; digit 0 = 1000000.
   - data=16'h0000 → only digit 0 lit (1000000).
4. blink_en=4'b0001, dp_in=4'b0010 → digit 0 lit for 64 cycles, dark for 64, repeating; digit 1 always shows dp_n=0. blank_mask=4'b0010 → digit 1 dark, including its DP.
5. Pulse load with new data mid-slot of digit 2 → seg changes exactly 1 cycle after the load edge; with load low, data toggling has no effect.
6. Assert rst_n=0 mid-frame with blink off-phase active:
   - next cycle: an=1111, seg=7'h7F, frame_done=0;
   - after release: the scan restarts at digit 0 with the shadow registers cleared, so the digit shows 0 (1000000).

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a bank of common-anode 7-segment digits.
// Display content is double-buffered in shadow registers captured on load. A prescaler
// walks one digit slot every SCAN_DIV cycles. Each slot opens with DEAD cycles of all
// anodes off to avoid ghosting. Pins are registered and lag the scan state by one cycle.
module seg7_scan_driver #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEAD         = 500,
  parameter int unsigned BLINK_FRAMES = 100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] data,
  input  logic                ext_mode,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   blank_mask,
  input  logic [DIGITS-1:0]   blink_en,
  input  logic                lz_en,
  output logic [6:0]          seg,
  output logic                dp_n,
  output logic [DIGITS-1:0]   an,
  output logic                frame_done
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PcntMax = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] DeadLen = PW'(DEAD);
  localparam logic [IW-1:0] IdxMax  = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FcntMax = FW'(BLINK_FRAMES - 1);

  // Segment patterns are gfedcba, active-low.
  function automatic logic [6:0] hex_seg(input logic [3:0] code);
    logic [6:0] s;
    unique case (code)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0011000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Extended alphabet only knows A, b and r; everything else is dark.
  function automatic logic [6:0] ext_seg(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b0101111;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Scan state
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          bph_q, bph_d;

  // Shadow registers
  logic [4*DIGITS-1:0] data_q, data_d;
  logic                ext_q, ext_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [DIGITS-1:0]   blink_q, blink_d;
  logic                lz_q, lz_d;

  // Registered pins
  logic [6:0]        seg_q, seg_d;
  logic              dp_n_q, dp_n_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_done_q, frame_done_d;

  logic pcnt_wrap, frame_wrap, blink_wrap;

  // Per-digit views of the shadow content
  logic [3:0]        nibs [DIGITS];
  logic [DIGITS-1:0] lz_supp;

  // Prescaler, digit index, frame counter and blink phase advance.
  always_comb begin
    pcnt_wrap  = (pcnt_q == PcntMax);
    frame_wrap = pcnt_wrap && (idx_q == IdxMax);
    blink_wrap = frame_wrap && (fcnt_q == FcntMax);

    pcnt_d = pcnt_wrap ? '0 : pcnt_q + PW'(1);

    idx_d = idx_q;
    if (pcnt_wrap) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + IW'(1);
    end

    fcnt_d = fcnt_q;
    bph_d  = bph_q;
    if (frame_wrap) begin
      fcnt_d = (fcnt_q == FcntMax) ? '0 : fcnt_q + FW'(1);
    end
    if (blink_wrap) begin
      bph_d = ~bph_q;
    end
  end

  // Shadow capture; inputs are ignored while load is low.
  always_comb begin
    data_d  = data_q;
    ext_d   = ext_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    blink_d = blink_q;
    lz_d    = lz_q;
    if (load) begin
      data_d  = data;
      ext_d   = ext_mode;
      dp_d    = dp_in;
      blank_d = blank_mask;
      blink_d = blink_en;
      lz_d    = lz_en;
    end
  end

  // Split the shadow word into per-digit nibbles.
  always_comb begin
    for (int i = 0; i < int'(DIGITS); i++) begin
      nibs[i] = data_q[4*i +: 4];
    end
  end

  // Leading-zero suppression: walk down from the top digit while every nibble seen is zero.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lz_supp    = '0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (data_q[4*i +: 4] == 4'h0);
      lz_supp[i] = lz_q & ~ext_q & upper_zero;
    end
  end

  // Pin values for the current scan state; they land in the pin registers at the next edge.
  always_comb begin
    logic       dead;
    logic       dark;
    logic [3:0] nib;
    dead = (pcnt_q < DeadLen);
    nib  = nibs[idx_q];
    dark = blank_q[idx_q] | (blink_q[idx_q] & bph_q) | lz_supp[idx_q];

    seg_d        = 7'h7F;
    dp_n_d       = 1'b1;
    an_d         = '1;
    frame_done_d = frame_wrap;

    if (!dead) begin
      // A dark digit still owns its slot; only its segments stay off.
      an_d = ~(DIGITS'(1) << idx_q);
      if (!dark) begin
        seg_d  = ext_q ? ext_seg(nib) : hex_seg(nib);
        dp_n_d = ~dp_q[idx_q];
      end
    end
  end

  // All state with synchronous active-low reset; reset also overrides load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      fcnt_q       <= '0;
      bph_q        <= 1'b0;
      data_q       <= '0;
      ext_q        <= 1'b0;
      dp_q         <= '0;
      blank_q      <= '0;
      blink_q      <= '0;
      lz_q         <= 1'b0;
      seg_q        <= 7'h7F;
      dp_n_q       <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      fcnt_q       <= fcnt_d;
      bph_q        <= bph_d;
      data_q       <= data_d;
      ext_q        <= ext_d;
      dp_q         <= dp_d;
      blank_q      <= blank_d;
      blink_q      <= blink_d;
      lz_q         <= lz_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
